// File: rtl/dma_pkg.sv
// Shared encodings for the DMA register-file sequencer: register file op/type
// codes and the channel state machine states.
package dma_pkg;

    localparam logic [1:0] OP_STORE = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;

    localparam logic [1:0] TYPE_MEM = 2'b00;
    localparam logic [1:0] TYPE_NOP = 2'b01;
    localparam logic [1:0] TYPE_IO  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        REQ_BUS,
        ISSUE,
        WAIT_ACK,
        NEXT,
        RELEASE
    } dmaState_t;

    function automatic logic [1:0] rfTypeFor(input logic devSel);
        return devSel ? TYPE_IO : TYPE_MEM;
    endfunction

    function automatic logic [1:0] rfOpFor(input logic dir);
        return dir ? OP_LOAD : OP_STORE;
    endfunction

endpackage

// File: rtl/dma_addr_cursor.sv
// Register/memory cursors and remaining-word counter for one DMA block.
// Cursors wrap naturally at their widths; the loaded count is clamped to the register file size.
module dma_addr_cursor
    import dma_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int MEM_AW = 8,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic              i_decrement,
    input  logic [REG_AW-1:0] i_reg_base,
    input  logic [MEM_AW-1:0] i_mem_base,
    input  logic [CNT_W-1:0]  i_count,
    output logic [REG_AW-1:0] o_cur_reg,
    output logic [MEM_AW-1:0] o_cur_mem,
    output logic [CNT_W-1:0]  o_remaining
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(2 ** REG_AW);

    logic [REG_AW-1:0] r_curReg;
    logic [MEM_AW-1:0] r_curMem;
    logic [CNT_W-1:0]  r_remaining;
    logic [CNT_W-1:0]  w_countClamped;

    assign w_countClamped = (i_count > MAX_CNT) ? MAX_CNT : i_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_curReg    <= '0;
            r_curMem    <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_curReg    <= i_reg_base;
            r_curMem    <= i_mem_base;
            r_remaining <= w_countClamped;
        end else begin
            if (i_advance) begin
                r_curReg <= r_curReg + REG_AW'(1);
                r_curMem <= r_curMem + MEM_AW'(1);
            end
            // Decrement may coincide with an advance on a grant-loss pause.
            if (i_decrement && (r_remaining != '0)) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end
        end
    end

    assign o_cur_reg   = r_curReg;
    assign o_cur_mem   = r_curMem;
    assign o_remaining = r_remaining;

endmodule

// File: rtl/dma_rf_sequencer.sv
// DMA channel controller: arbitrates for the bus, then moves a block of words
// between the register file and memory/IO one mem_req/mem_ack handshake at a time.
module dma_rf_sequencer
    import dma_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int MEM_AW = 8,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_dir,
    input  logic              i_dev_sel,
    input  logic [REG_AW-1:0] i_reg_base,
    input  logic [MEM_AW-1:0] i_mem_base,
    input  logic [CNT_W-1:0]  i_count,
    input  logic              i_abort,
    output logic              o_bus_req,
    input  logic              i_bus_grant,
    output logic              o_mem_req,
    output logic [MEM_AW-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    output logic [1:0]        o_rf_op,
    output logic [1:0]        o_rf_type,
    output logic [MEM_AW-1:0] o_rf_next_source,
    output logic [MEM_AW-1:0] o_rf_destination,
    output logic              o_rf_regwrite,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_aborted,
    output logic [CNT_W-1:0]  o_remaining
);

    dmaState_t r_state;
    dmaState_t w_stateNext;

    logic r_dir;
    logic r_devSel;
    logic r_zeroDone;
    logic r_abortPend;

    logic w_load;
    logic w_advance;
    logic w_decrement;
    logic w_abort;

    logic [REG_AW-1:0] w_curReg;
    logic [MEM_AW-1:0] w_curMem;
    logic [CNT_W-1:0]  w_remaining;

    dma_addr_cursor #(
        .REG_AW (REG_AW),
        .MEM_AW (MEM_AW),
        .CNT_W  (CNT_W)
    ) u_cursor (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_advance   (w_advance),
        .i_decrement (w_decrement),
        .i_reg_base  (i_reg_base),
        .i_mem_base  (i_mem_base),
        .i_count     (i_count),
        .o_cur_reg   (w_curReg),
        .o_cur_mem   (w_curMem),
        .o_remaining (w_remaining)
    );

    // A short abort pulse during a word is remembered so the word can finish first.
    assign w_abort = i_abort | r_abortPend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_dir       <= 1'b0;
            r_devSel    <= 1'b0;
            r_zeroDone  <= 1'b0;
            r_abortPend <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_zeroDone <= (r_state == IDLE) && i_start && (i_count == '0);
            if ((r_state == IDLE) && i_start) begin
                r_dir    <= i_dir;
                r_devSel <= i_dev_sel;
            end
            if ((r_state == IDLE) || (r_state == RELEASE)) begin
                r_abortPend <= 1'b0;
            end else if (i_abort) begin
                r_abortPend <= 1'b1;
            end
        end
    end

    always_comb begin
        w_stateNext      = r_state;
        w_load           = 1'b0;
        w_advance        = 1'b0;
        w_decrement      = 1'b0;
        o_bus_req        = 1'b0;
        o_mem_req        = 1'b0;
        o_mem_addr       = '0;
        o_rf_op          = OP_STORE;
        o_rf_type        = TYPE_NOP;
        o_rf_next_source = '0;
        o_rf_destination = '0;
        o_rf_regwrite    = 1'b0;
        o_done           = r_zeroDone;
        o_aborted        = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_load = 1'b1;
                    if (i_count != '0) begin
                        w_stateNext = REQ_BUS;
                    end
                end
            end

            REQ_BUS: begin
                o_bus_req = 1'b1;
                if (w_abort) begin
                    w_stateNext = RELEASE;
                end else if (i_bus_grant) begin
                    w_stateNext = ISSUE;
                end
            end

            ISSUE, WAIT_ACK: begin
                o_bus_req        = 1'b1;
                o_mem_req        = 1'b1;
                o_mem_addr       = w_curMem;
                o_rf_op          = rfOpFor(r_dir);
                o_rf_type        = rfTypeFor(r_devSel);
                o_rf_next_source = MEM_AW'(w_curReg);
                o_rf_destination = MEM_AW'(w_curReg);
                o_rf_regwrite    = r_dir;
                if (r_state == ISSUE) begin
                    w_stateNext = WAIT_ACK;
                end else if (i_mem_ack) begin
                    w_decrement = 1'b1;
                    if ((w_remaining == CNT_W'(1)) || w_abort) begin
                        w_stateNext = RELEASE;
                    end else if (!i_bus_grant) begin
                        // Step past the finished word so the resumed block picks up at the next one.
                        w_advance   = 1'b1;
                        w_stateNext = REQ_BUS;
                    end else begin
                        w_stateNext = NEXT;
                    end
                end
            end

            NEXT: begin
                o_bus_req = 1'b1;
                if (w_abort) begin
                    w_stateNext = RELEASE;
                end else begin
                    w_advance   = 1'b1;
                    w_stateNext = ISSUE;
                end
            end

            RELEASE: begin
                o_done      = 1'b1;
                o_aborted   = (w_remaining != '0);
                w_stateNext = IDLE;
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign o_busy      = (r_state != IDLE);
    assign o_remaining = w_remaining;

endmodule

// File: tb/tb_dma_rf_sequencer.sv
// Scoreboard bench for dma_rf_sequencer: directed transfers push expected words and
// completions; a negedge monitor acts as memory/IO responder and checks what the DUT presents.
module tb_dma_rf_sequencer;
    import dma_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       dir = 1'b0;
    logic       devSel = 1'b0;
    logic [3:0] regBase = '0;
    logic [7:0] memBase = '0;
    logic [4:0] count = '0;
    logic       abort = 1'b0;
    logic       busReq;
    logic       busGrant = 1'b0;
    logic       memReq;
    logic [7:0] memAddr;
    logic       memAck = 1'b0;
    logic [1:0] rfOp;
    logic [1:0] rfType;
    logic [7:0] rfNextSource;
    logic [7:0] rfDestination;
    logic       rfRegwrite;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [4:0] remaining;

    typedef struct {
        logic [7:0] addr;
        logic [3:0] regIdx;
        logic [1:0] op;
        logic [1:0] typ;
        logic       wr;
        int         delay;
    } wordExp_t;

    typedef struct {
        logic       aborted;
        logic [4:0] remaining;
    } doneExp_t;

    wordExp_t expQ[$];
    doneExp_t doneQ[$];

    int checks = 0;
    int errors = 0;
    int ackCount = 0;
    int reqCycles = 0;
    int grantCnt = 0;
    int grantDelay = 2;
    bit grantEnable = 1'b1;

    dma_rf_sequencer #(.REG_AW(4), .MEM_AW(8), .CNT_W(5)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (start),
        .i_dir            (dir),
        .i_dev_sel        (devSel),
        .i_reg_base       (regBase),
        .i_mem_base       (memBase),
        .i_count          (count),
        .i_abort          (abort),
        .o_bus_req        (busReq),
        .i_bus_grant      (busGrant),
        .o_mem_req        (memReq),
        .o_mem_addr       (memAddr),
        .i_mem_ack        (memAck),
        .o_rf_op          (rfOp),
        .o_rf_type        (rfType),
        .o_rf_next_source (rfNextSource),
        .o_rf_destination (rfDestination),
        .o_rf_regwrite    (rfRegwrite),
        .o_busy           (busy),
        .o_done           (done),
        .o_aborted        (aborted),
        .o_remaining      (remaining)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushWord(input logic [7:0] addr, input logic [3:0] regIdx, input logic [1:0] op,
                            input logic [1:0] typ, input logic wr, input int delay);
        wordExp_t e;
        e.addr = addr; e.regIdx = regIdx; e.op = op; e.typ = typ; e.wr = wr; e.delay = delay;
        expQ.push_back(e);
    endtask

    task automatic pushDone(input logic ab, input logic [4:0] rem);
        doneExp_t d;
        d.aborted = ab; d.remaining = rem;
        doneQ.push_back(d);
    endtask

    task automatic applyStimulus(input logic d, input logic dev, input logic [3:0] rb,
                                 input logic [7:0] mb, input logic [4:0] cnt);
        @(negedge clk);
        dir = d; devSel = dev; regBase = rb; memBase = mb; count = cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitForDone(input string name, input int maxCycles);
        int n = 0;
        while ((doneQ.size() != 0 || busy) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput({name, "_timeout"}, 64'(n >= maxCycles), 64'(0));
        checkOutput({name, "_pending_words"}, 64'(expQ.size()), 64'(0));
        checkOutput({name, "_pending_done"}, 64'(doneQ.size()), 64'(0));
    endtask

    // Bus arbiter model: grants a configurable number of cycles after bus_req rises.
    always @(negedge clk) begin
        if (!busReq || !grantEnable) begin
            grantCnt = 0;
            busGrant = 1'b0;
        end else begin
            grantCnt++;
            busGrant = (grantCnt > grantDelay);
        end
    end

    // Memory/IO responder and scoreboard monitor: every cycle a word is presented it
    // must match the head entry; the ack arrives after that entry's extra delay.
    always @(negedge clk) begin : monitor
        wordExp_t e;
        doneExp_t d;
        if (memReq) begin
            reqCycles++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_word: got addr 0x%0h with no word expected", memAddr);
                memAck = (reqCycles >= 2);
            end else begin
                e = expQ[0];
                checkOutput("word", 64'({memAddr, rfOp, rfType, rfNextSource, rfDestination, rfRegwrite}),
                            64'({e.addr, e.op, e.typ, 8'(e.regIdx), 8'(e.regIdx), e.wr}));
                if (reqCycles == 2 + e.delay) begin
                    memAck = 1'b1;
                    void'(expQ.pop_front());
                    ackCount++;
                end else begin
                    memAck = 1'b0;
                end
            end
        end else begin
            reqCycles = 0;
            memAck = 1'b0;
        end
        if (done) begin
            if (doneQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done with remaining %0d, none expected", remaining);
            end else begin
                d = doneQ.pop_front();
                checkOutput("done", 64'({aborted, remaining, busReq}), 64'({d.aborted, d.remaining, 1'b0}));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int startAck;
        int n;
        bit seen;

        repeat (2) @(negedge clk);
        checkOutput("reset_rf_type", 64'(rfType), 64'(TYPE_NOP));
        checkOutput("reset_ctrl", 64'({busy, done, aborted, busReq, memReq, rfRegwrite}), 64'(0));
        checkOutput("reset_buses", 64'({memAddr, rfOp, rfNextSource, rfDestination, remaining}), 64'(0));
        rst_n = 1'b1;

        $display("[TB] store 4 words to memory");
        grantDelay = 2;
        for (int i = 0; i < 4; i++) pushWord(8'h10 + 8'(i), 4'(2 + i), OP_STORE, TYPE_MEM, 1'b0, 0);
        pushDone(1'b0, 5'd0);
        applyStimulus(1'b0, 1'b0, 4'd2, 8'h10, 5'd4);
        waitForDone("store4", 100);

        $display("[TB] load 4 words from IO with wrap");
        pushWord(8'hFE, 4'd14, OP_LOAD, TYPE_IO, 1'b1, 0);
        pushWord(8'hFF, 4'd15, OP_LOAD, TYPE_IO, 1'b1, 0);
        pushWord(8'h00, 4'd0,  OP_LOAD, TYPE_IO, 1'b1, 0);
        pushWord(8'h01, 4'd1,  OP_LOAD, TYPE_IO, 1'b1, 0);
        pushDone(1'b0, 5'd0);
        applyStimulus(1'b1, 1'b1, 4'd14, 8'hFE, 5'd4);
        waitForDone("load_wrap", 100);

        $display("[TB] slow ack on word 2 of 3");
        startAck = ackCount;
        pushWord(8'h40, 4'd0, OP_STORE, TYPE_MEM, 1'b0, 0);
        pushWord(8'h41, 4'd1, OP_STORE, TYPE_MEM, 1'b0, 5);
        pushWord(8'h42, 4'd2, OP_STORE, TYPE_MEM, 1'b0, 0);
        pushDone(1'b0, 5'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h40, 5'd3);
        waitForDone("slow_ack", 100);
        checkOutput("slow_ack_count", 64'(ackCount - startAck), 64'(3));

        $display("[TB] grant loss during word 1 of 3");
        grantDelay = 1;
        startAck = ackCount;
        pushWord(8'h80, 4'd5, OP_LOAD, TYPE_MEM, 1'b1, 0);
        pushWord(8'h81, 4'd6, OP_LOAD, TYPE_MEM, 1'b1, 0);
        pushWord(8'h82, 4'd7, OP_LOAD, TYPE_MEM, 1'b1, 0);
        pushDone(1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 4'd5, 8'h80, 5'd3);
        n = 0;
        while (!memReq && n < 50) begin @(negedge clk); n++; end
        checkOutput("grant_loss_issue_timeout", 64'(n >= 50), 64'(0));
        grantEnable = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("grant_loss_pause", 64'({memReq, busReq, busy, rfOp, rfType, remaining}),
                    64'({1'b0, 1'b1, 1'b1, OP_STORE, TYPE_NOP, 5'd2}));
        checkOutput("grant_loss_acks_so_far", 64'(ackCount - startAck), 64'(1));
        repeat (3) @(negedge clk);
        checkOutput("grant_loss_hold", 64'({memReq, busReq}), 64'({1'b0, 1'b1}));
        grantEnable = 1'b1;
        waitForDone("grant_loss", 100);
        checkOutput("grant_loss_acks", 64'(ackCount - startAck), 64'(3));

        $display("[TB] abort in WAIT_ACK on word 2 of 8");
        startAck = ackCount;
        pushWord(8'h20, 4'd8, OP_STORE, TYPE_IO, 1'b0, 0);
        pushWord(8'h21, 4'd9, OP_STORE, TYPE_IO, 1'b0, 3);
        pushDone(1'b1, 5'd6);
        applyStimulus(1'b0, 1'b1, 4'd8, 8'h20, 5'd8);
        n = 0;
        while (!(memReq && memAddr == 8'h21) && n < 50) begin @(negedge clk); n++; end
        checkOutput("abort_word2_timeout", 64'(n >= 50), 64'(0));
        @(negedge clk);
        abort = 1'b1;
        waitForDone("abort", 100);
        abort = 1'b0;
        checkOutput("abort_acks", 64'(ackCount - startAck), 64'(2));

        $display("[TB] count=0 start");
        pushDone(1'b0, 5'd0);
        applyStimulus(1'b0, 1'b0, 4'd3, 8'h55, 5'd0);
        seen = 1'b0;
        repeat (4) begin @(negedge clk); seen |= busReq; end
        checkOutput("zero_count_bus_req", 64'(seen), 64'(0));
        waitForDone("zero_count", 10);

        $display("[TB] count=20 clamps to 16 words");
        grantDelay = 0;
        startAck = ackCount;
        for (int i = 0; i < 16; i++) pushWord(8'(i), 4'(i), OP_STORE, TYPE_MEM, 1'b0, 0);
        pushDone(1'b0, 5'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 5'd20);
        waitForDone("clamp", 200);
        checkOutput("clamp_acks", 64'(ackCount - startAck), 64'(16));

        $display("[TB] reset mid-transfer");
        grantDelay = 1;
        for (int i = 0; i < 4; i++) pushWord(8'h30 + 8'(i), 4'(i), OP_STORE, TYPE_MEM, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h30, 5'd4);
        n = 0;
        while (!memReq && n < 50) begin @(negedge clk); n++; end
        checkOutput("reset_mid_issue_timeout", 64'(n >= 50), 64'(0));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_rf_type", 64'(rfType), 64'(TYPE_NOP));
        checkOutput("reset_mid_ctrl", 64'({busy, busReq, memReq, remaining}), 64'(0));
        expQ.delete();
        doneQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_reset_idle", 64'({busy, busReq, done}), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
